// File: rtl/gray_stream_decoder_pkg.sv
// gray_stream_decoder_pkg: shared parameter defaults and the gray-to-binary helper
package gray_stream_decoder_pkg;
  localparam int DW_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int GW_MAX = 32;
  // Operates on a zero-extended word so any DW up to GW_MAX decodes identically
  function automatic logic [GW_MAX-1:0] gray2bin(input logic [GW_MAX-1:0] g);
    logic [GW_MAX-1:0] b;
    b = '0;
    for (int i = 0; i < GW_MAX; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray_stream_decoder_if.sv
// gray_stream_decoder_if: valid/ready word stream shared by the decoder input and output
interface gray_stream_decoder_if #(parameter int DW = 8) ();
  logic vld;
  logic [DW-1:0] data;
  logic rdy;
  modport master (output vld, data, input rdy);
  modport slave (input vld, data, output rdy);
endinterface

// File: rtl/gray_stream_decoder_fifo.sv
// gray_stream_decoder_fifo: first-word-fall-through FIFO with push-when-full-if-popping
module gray_stream_decoder_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic wr_en, rd_en;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en = pop & !empty;
  assign wr_en = push & (!full | rd_en);
  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
  // Next pointers and storage contents
  always_comb begin
    wr_d = wr_q + (AW+1)'(wr_en);
    rd_d = rd_q + (AW+1)'(rd_en);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = din;
  end
  // Pointer registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // Storage needs no reset; the empty gate hides stale words
  always_ff @(posedge i_clk) mem_q <= mem_d;
endmodule

// File: rtl/gray_stream_decoder.sv
// gray_stream_decoder: decodes a gray ramp, checks its continuity and buffers results
module gray_stream_decoder
  import gray_stream_decoder_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  gray_stream_decoder_if.slave  s_in,
  gray_stream_decoder_if.master m_out,
  output logic                 o_seq_err,
  output logic [CNT_W-1:0]     o_err_cnt,
  output logic [CNT_W-1:0]     o_drop_cnt,
  output logic                 o_ovf
);
  logic s1_vld_q, s1_vld_d, ref_valid_q, ref_valid_d, seq_err_q, seq_err_d, ovf_q, ovf_d;
  logic [DW-1:0] s1_gray_q, s1_gray_d, prev_gray_q, prev_gray_d, prev_bin_q, prev_bin_d, bin;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
  logic full, empty, pop, drop, err;
  assign s_in.rdy = 1'b1;
  assign bin = DW'(gray2bin(GW_MAX'(s1_gray_q)));
  assign pop = m_out.vld & m_out.rdy;
  assign drop = s1_vld_q & full & !pop;
  assign err = s1_vld_q & ref_valid_q & !i_clr &
               ((bin != prev_bin_q + DW'(1)) | ($countones(s1_gray_q ^ prev_gray_q) != 1));
  assign m_out.vld = !empty;
  assign o_seq_err = seq_err_q;
  assign o_err_cnt = err_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
  assign o_ovf = ovf_q;
  gray_stream_decoder_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .push(s1_vld_q), .din(bin), .full(full),
    .pop(pop), .dout(m_out.data), .empty(empty)
  );
  // Input capture, reference tracking, error pulse and saturating counters
  always_comb begin
    s1_vld_d = s_in.vld;
    s1_gray_d = s_in.data;
    prev_gray_d = s1_vld_q ? s1_gray_q : prev_gray_q;
    prev_bin_d = s1_vld_q ? bin : prev_bin_q;
    ref_valid_d = !i_clr & (s1_vld_q | ref_valid_q);
    seq_err_d = err;
    err_cnt_d = i_clr ? '0 : (err && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    drop_cnt_d = i_clr ? '0 : (drop && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    ovf_d = !i_clr & (ovf_q | drop);
  end
  // State registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_vld_q <= 1'b0;
      s1_gray_q <= '0;
      prev_gray_q <= '0;
      prev_bin_q <= '0;
      ref_valid_q <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
      drop_cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_gray_q <= s1_gray_d;
      prev_gray_q <= prev_gray_d;
      prev_bin_q <= prev_bin_d;
      ref_valid_q <= ref_valid_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
